// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and width helpers for stack variants
package stack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 64;

    // Count must represent 0..depth inclusive, hence depth+1 states.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for depth entries; depth >= 2 keeps this >= 1.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH storage, sync write, async read
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // No reset: contents are only observable below the live count.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with count, flags, peek and flush
// Ports: clk, reset (async active-low), enable, clear, push/push_data, pop;
// outputs pop_data/pop_valid (registered), top (peek), count, empty, full,
// almost_full, sticky overflow/underflow.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2,
    parameter int CW        = calc_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = calc_aw(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] mem_rdata;

    // Wraps when empty, but the read result is masked in that case.
    assign top_addr = AW'(count_q - CW'(1));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (mem_rdata)
    );

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign top         = empty ? '0 : mem_rdata;
    assign count       = count_q;
    assign pop_data    = pop_data_q;
    assign pop_valid   = pop_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = AW'(count_q);

        if (enable) begin
            if (clear) begin
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end else if (push && pop) begin
                if (empty) begin
                    // Push lands in slot 0; pop is refused, no bypass.
                    mem_we      = 1'b1;
                    mem_waddr   = '0;
                    count_d     = CW'(1);
                    underflow_d = 1'b1;
                end else begin
                    // Replace the top in place; count stays, even when full.
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    mem_we      = 1'b1;
                    mem_waddr   = top_addr;
                end
            end else if (push) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - scoreboard bench for lifo_stack against a queue model
module tb_lifo_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             clear;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stack itself is a queue, back = top.
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_last = '0;
    logic             m_pv   = 1'b0;
    logic             m_ov   = 1'b0;
    logic             m_un   = 1'b0;
    logic             mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        exp_q.delete();
        m_last = '0;
        m_pv   = 1'b0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic ps,
                              input logic pp, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] old;
        m_pv = 1'b0;
        if (!e) begin
            // frozen
        end else if (c) begin
            stk.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (ps && pp) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                m_un = 1'b1;
            end else begin
                old = stk.pop_back();
                stk.push_back(d);
                exp_q.push_back(old);
                m_last = old;
                m_pv   = 1'b1;
            end
        end else if (ps) begin
            if (stk.size() == DEPTH) m_ov = 1'b1;
            else                     stk.push_back(d);
        end else if (pp) begin
            if (stk.size() == 0) begin
                m_un = 1'b1;
            end else begin
                old = stk.pop_back();
                exp_q.push_back(old);
                m_last = old;
                m_pv   = 1'b1;
            end
        end
    endtask

    // One clock of stimulus; returns at the following falling edge.
    task automatic step(input logic e, input logic c, input logic ps,
                        input logic pp, input logic [WIDTH-1:0] d);
        enable    = e;
        clear     = c;
        push      = ps;
        pop       = pp;
        push_data = d;
        @(posedge clk);
        model_step(e, c, ps, pp, d);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: compares DUT state and pop strobes against the model each cycle.
    initial begin
        logic [WIDTH-1:0] e_top;
        logic [WIDTH-1:0] e_pd;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                e_top = (stk.size() == 0) ? '0 : stk[stk.size() - 1];
                chk("count", 32'(count), 32'(stk.size()));
                chk("top", 32'(top), 32'(e_top));
                chk("empty", 32'(empty), 32'(stk.size() == 0));
                chk("full", 32'(full), 32'(stk.size() == DEPTH));
                chk("almost_full", 32'(almost_full), 32'(stk.size() >= AFULL));
                chk("overflow", 32'(overflow), 32'(m_ov));
                chk("underflow", 32'(underflow), 32'(m_un));
                chk("pop_valid", 32'(pop_valid), 32'(m_pv));
                if (pop_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", 32'(pop_valid), 32'd0);
                    end else begin
                        e_pd = exp_q.pop_front();
                        chk("pop_data", 32'(pop_data), 32'(e_pd));
                    end
                end else begin
                    chk("pop_data_hold", 32'(pop_data), 32'(m_last));
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        model_reset();
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic LIFO order.
        step(1, 0, 1, 0, 16'h1111);
        step(1, 0, 1, 0, 16'h2222);
        step(1, 0, 1, 0, 16'h3333);
        step(1, 0, 0, 1, '0);
        step(1, 0, 0, 1, '0);
        step(1, 0, 0, 1, '0);
        idle();

        // Fill, overflow, flush.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 16'(16'h4000 + i));
        step(1, 0, 1, 0, 16'hDEAD);
        idle();
        step(1, 1, 0, 0, '0);

        // Underflow, then push+pop on empty.
        step(1, 0, 0, 1, '0);
        step(1, 0, 1, 1, 16'hAAAA);
        idle();
        step(1, 1, 0, 0, '0);

        // Push+pop while full.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 16'(16'h5000 + i));
        step(1, 0, 1, 1, 16'hBEEF);
        idle();

        // Freeze with everything toggling; a pop just before checks the strobe drops.
        step(1, 0, 0, 1, '0);
        for (int i = 0; i < 5; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom));
        idle();

        // Async reset between edges with count=2.
        step(1, 1, 0, 0, '0);
        step(1, 0, 1, 0, 16'h7777);
        step(1, 0, 1, 0, 16'h8888);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_top", 32'(top), 32'd0);
        model_reset();
        #1;
        reset = 1'b1;
        step(1, 0, 1, 0, 16'h9999);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        idle();
        idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
